// File: rtl/dmp_ld_return_if.sv
// Load-return bus bundle between the pipeline, the three load targets
// (DCCM, ICCM, peripheral) and the return-tracking block.
interface dmp_ld_return_if;
    logic        ld_req;
    logic        is_ldst_ram;
    logic        is_code_ram;
    logic        is_peripheral;
    logic        ldst_dvalid;
    logic        code_dvalid;
    logic        per_dvalid;
    logic [31:0] ldst_drd;
    logic [31:0] code_drd;
    logic [31:0] per_drd;
    logic        holdup_ld;
    logic        ld_accept;
    logic        ld_dvalid;
    logic [31:0] ld_drd;
    logic        ld_err;
    logic [1:0]  outstanding;

    // Return-tracking block side
    modport slave (
        input  ld_req, is_ldst_ram, is_code_ram, is_peripheral,
        input  ldst_dvalid, code_dvalid, per_dvalid,
        input  ldst_drd, code_drd, per_drd,
        output holdup_ld, ld_accept, ld_dvalid, ld_drd, ld_err, outstanding
    );

    // Pipeline / target side
    modport master (
        output ld_req, is_ldst_ram, is_code_ram, is_peripheral,
        output ldst_dvalid, code_dvalid, per_dvalid,
        output ldst_drd, code_drd, per_drd,
        input  holdup_ld, ld_accept, ld_dvalid, ld_drd, ld_err, outstanding
    );
endinterface

// File: rtl/dmp_ld_return.sv
// Load-return tracker: counts outstanding loads to a single target at a
// time, stalls requests that would mix targets or overflow, and forwards the
// matching target's return data (or a bus error for unmapped loads).
module dmp_ld_return #(
    parameter int unsigned MAX_OUT = 3
) (
    input  logic            clk,
    input  logic            rst_a,
    dmp_ld_return_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_LDST,
        BUSY_CODE,
        BUSY_PER,
        ERR
    } state_t;

    state_t      r_state;
    logic [1:0]  r_count;
    logic        r_dvalid;
    logic        r_err;
    logic [31:0] r_drd;

    logic        w_unmapped;
    logic        w_tgt_match;
    logic        w_full;
    logic        w_busy;
    logic        w_holdup;
    logic        w_accept;
    logic        w_ret;
    logic [31:0] w_ret_data;
    state_t      w_tgt_state;

    // Target decode, stall decision and return selection for the current target
    always_comb begin
        w_unmapped  = ~(bus.is_ldst_ram | bus.is_code_ram | bus.is_peripheral);
        w_tgt_state = IDLE;
        if (bus.is_ldst_ram)        w_tgt_state = BUSY_LDST;
        else if (bus.is_code_ram)   w_tgt_state = BUSY_CODE;
        else if (bus.is_peripheral) w_tgt_state = BUSY_PER;

        w_tgt_match = ~w_unmapped && (w_tgt_state == r_state);
        w_full      = (r_count == 2'(MAX_OUT));
        w_busy      = (r_count != 2'd0);
        w_holdup    = bus.ld_req & ((r_state == ERR) | w_full | (w_busy & ~w_tgt_match));
        w_accept    = bus.ld_req & ~w_holdup;

        w_ret      = 1'b0;
        w_ret_data = '0;
        case (r_state)
            BUSY_LDST: begin
                w_ret      = bus.ldst_dvalid;
                w_ret_data = bus.ldst_drd;
            end
            BUSY_CODE: begin
                w_ret      = bus.code_dvalid;
                w_ret_data = bus.code_drd;
            end
            BUSY_PER: begin
                w_ret      = bus.per_dvalid;
                w_ret_data = bus.per_drd;
            end
            default: begin
                w_ret      = 1'b0;
                w_ret_data = '0;
            end
        endcase
        w_ret = w_ret & w_busy;
    end

    // State, outstanding count and registered return outputs
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_dvalid <= 1'b0;
            r_err    <= 1'b0;
            r_drd    <= '0;
        end else begin
            r_dvalid <= 1'b0;
            r_err    <= 1'b0;
            if (w_ret) begin
                r_dvalid <= 1'b1;
                r_drd    <= w_ret_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_unmapped) begin
                            r_state  <= ERR;
                            r_dvalid <= 1'b1;
                            r_err    <= 1'b1;
                            r_drd    <= '0;
                        end else begin
                            r_state <= w_tgt_state;
                            r_count <= 2'd1;
                        end
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    // Simultaneous accept and return cancel out on the count
                    if (w_accept && !w_ret) begin
                        r_count <= r_count + 2'd1;
                    end else if (!w_accept && w_ret) begin
                        r_count <= r_count - 2'd1;
                        if (r_count == 2'd1) r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.holdup_ld   = w_holdup;
    assign bus.ld_accept   = w_accept;
    assign bus.ld_dvalid   = r_dvalid;
    assign bus.ld_err      = r_err;
    assign bus.ld_drd      = r_drd;
    assign bus.outstanding = r_count;

endmodule
